// File: rtl/tuple_serializer_pkg.sv
// Shared types and defaults for the tuple serializer and its helpers.
package tuple_pkg;

    localparam int TUPLE_ENTRIES = 8;
    localparam int TUPLE_DATA_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Field index width for a given field count; a single field still needs one bit.
    function automatic int addr_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/tuple_serializer_if.sv
// Tuple input stream and (addr, data) beat output stream of the serializer.
interface tuple_serializer_if #(
    parameter int ENTRIES = tuple_pkg::TUPLE_ENTRIES,
    parameter int DATA_W  = tuple_pkg::TUPLE_DATA_W,
    parameter int ADDR_W  = tuple_pkg::addr_w(ENTRIES)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [ENTRIES*DATA_W-1:0]   in_tuple;
    logic [ENTRIES-1:0]          in_mask;

    logic                        out_valid;
    logic                        out_ready;
    logic [ADDR_W-1:0]           out_addr;
    logic [DATA_W-1:0]           out_data;
    logic                        out_last;

    // The serializer: consumes tuples, produces beats.
    modport slave (
        input  in_valid, in_tuple, in_mask, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_last
    );

    // The environment: offers tuples, sinks beats.
    modport master (
        output in_valid, in_tuple, in_mask, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_last
    );

endinterface

// File: rtl/tuple_serializer_first_set.sv
// Lowest-set-bit priority encoder over a field mask.
module tuple_first_set #(
    parameter int ENTRIES = tuple_pkg::TUPLE_ENTRIES,
    parameter int ADDR_W  = tuple_pkg::addr_w(ENTRIES)
) (
    input  logic [ENTRIES-1:0] i_mask,
    output logic [ADDR_W-1:0]  o_idx,
    output logic               o_found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx   = ADDR_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tuple_serializer.sv
// Walks a captured packed tuple and emits each masked field as an (addr, data) beat,
// lowest index first. One tuple in flight at a time.
module tuple_serializer
    import tuple_pkg::*;
#(
    parameter int ENTRIES = TUPLE_ENTRIES,
    parameter int DATA_W  = TUPLE_DATA_W,
    parameter int ADDR_W  = addr_w(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    tuple_serializer_if.slave bus,
    output logic              busy
);

    state_e                    r_state;
    state_e                    w_state_next;
    logic [ENTRIES*DATA_W-1:0] r_tuple;
    logic [ENTRIES-1:0]        r_mask;
    logic [ADDR_W-1:0]         r_idx;

    logic                      w_capture;
    logic                      w_advance;
    logic [ADDR_W-1:0]         w_first_idx;
    logic                      w_first_found;
    logic [ENTRIES-1:0]        w_above;
    logic [ADDR_W-1:0]         w_next_idx;
    logic                      w_next_found;

    // Starting field of a newly offered tuple.
    tuple_first_set #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_first (
        .i_mask  (bus.in_mask),
        .o_idx   (w_first_idx),
        .o_found (w_first_found)
    );

    // Pending fields strictly above the current one.
    always_comb begin
        w_above = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (i > int'(r_idx)) begin
                w_above[i] = r_mask[i];
            end
        end
    end

    // Next field to emit; nothing found means the current beat is the last.
    tuple_first_set #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_next (
        .i_mask  (w_above),
        .o_idx   (w_next_idx),
        .o_found (w_next_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and datapath enables.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_capture = 1'b1;
                    // An empty mask is consumed without emitting anything.
                    if (w_first_found) begin
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    w_advance = 1'b1;
                    if (!w_next_found) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Captured tuple, remaining mask and current field index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tuple <= '0;
            r_mask  <= '0;
            r_idx   <= '0;
        end else if (w_capture) begin
            r_tuple <= bus.in_tuple;
            r_mask  <= bus.in_mask;
            r_idx   <= w_first_idx;
        end else if (w_advance) begin
            // Bits at and below idx are already done, so keeping only the upper ones clears bit idx.
            r_mask <= w_above;
            if (w_next_found) begin
                r_idx <= w_next_idx;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_SEND);
    assign bus.out_addr  = r_idx;
    assign bus.out_data  = r_tuple[int'(r_idx)*DATA_W +: DATA_W];
    assign bus.out_last  = (r_state == ST_SEND) && !w_next_found;
    assign busy          = (r_state == ST_SEND);

endmodule
